// File: rtl/ccff_prog_ctrl_if.sv
// Configuration word stream carrying 32-bit words into the programming controller.
// No internal latency; a word moves on any prog_clk edge where cfg_valid and cfg_ready are both 1.
// The consumer throttles with cfg_ready; the producer may hold cfg_valid low for any number of cycles.
//
// Signals: cfg_data (32b word, LSB shifted first), cfg_valid (producer has a word),
//          cfg_ready (consumer takes the word this cycle).
interface ccff_prog_ctrl_if;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_prog_ctrl.sv
// Programs a configuration flip-flop chain bit-serially from 32-bit words, with CRC-16 and optional readback verify.
// One chain bit per cycle inside a word, one idle FETCH cycle between words, done one cycle after the last shift/verify bit.
// Stalls indefinitely in FETCH while cfg_valid is low; start is ignored while busy.
//
// Ports: prog_clk / pReset (sync, active-high); start, chain_len, verify_en (latched on an accepted start);
//        cfg (word stream, slave side); ccff_head / ccff_shift_en / ccff_tail (chain serial interface);
//        busy, done (1-cycle pulse), crc_err (sticky until next start), crc_value (CRC of bits shifted in).
module ccff_prog_ctrl (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   start,
    input  logic [15:0]            chain_len,
    input  logic                   verify_en,
    ccff_prog_ctrl_if.slave        cfg,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    input  logic                   ccff_tail,
    output logic                   busy,
    output logic                   done,
    output logic                   crc_err,
    output logic [15:0]            crc_value
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] len_q;
    logic        ver_q;
    logic [15:0] bit_cnt;
    logic [4:0]  word_cnt;
    logic [15:0] ver_cnt;
    logic [31:0] shreg;
    logic [15:0] crc_q;
    logic [15:0] crc2_q;
    logic        crc_err_q;
    logic        ready_q;
    logic        shift_en_q;
    logic        head_q;
    logic        loop_q;
    logic        busy_q;
    logic        done_q;

    logic        last_bit;
    logic        ver_last;
    logic [15:0] crc2_next;

    // CRC-16-CCITT, one bit per call.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        last_bit  = ((bit_cnt + 16'd1) == len_q);
        ver_last  = ((ver_cnt + 16'd1) == len_q);
        crc2_next = crc_step(crc2_q, ccff_tail);
    end

    // All outputs come straight from flops. The only combinational path is the
    // VERIFY loopback, which rotates the chain through itself so it ends intact.
    assign cfg.cfg_ready = ready_q;
    assign ccff_shift_en = shift_en_q;
    assign ccff_head     = loop_q ? ccff_tail : head_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign crc_err       = crc_err_q;
    assign crc_value     = crc_q;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state      <= IDLE;
            len_q      <= '0;
            ver_q      <= 1'b0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            ver_cnt    <= '0;
            shreg      <= '0;
            crc_q      <= 16'hFFFF;
            crc2_q     <= 16'hFFFF;
            crc_err_q  <= 1'b0;
            ready_q    <= 1'b0;
            shift_en_q <= 1'b0;
            head_q     <= 1'b0;
            loop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= chain_len;
                        ver_q     <= verify_en;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        ver_cnt   <= '0;
                        crc_q     <= 16'hFFFF;
                        crc_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (chain_len == 16'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            ready_q <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    if (cfg.cfg_valid) begin
                        // head_q is pre-loaded with the bit the first SHIFT cycle presents.
                        shreg      <= cfg.cfg_data;
                        head_q     <= cfg.cfg_data[0];
                        word_cnt   <= '0;
                        ready_q    <= 1'b0;
                        shift_en_q <= 1'b1;
                        state      <= SHIFT;
                    end
                end

                SHIFT: begin
                    crc_q    <= crc_step(crc_q, shreg[0]);
                    shreg    <= shreg >> 1;
                    bit_cnt  <= bit_cnt + 16'd1;
                    word_cnt <= word_cnt + 5'd1;
                    if (last_bit) begin
                        // Remaining bits of the current word are dropped.
                        head_q <= 1'b0;
                        if (ver_q) begin
                            state      <= VERIFY;
                            loop_q     <= 1'b1;
                            shift_en_q <= 1'b1;
                            ver_cnt    <= '0;
                            crc2_q     <= 16'hFFFF;
                        end else begin
                            state      <= DONE;
                            shift_en_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end else if (word_cnt == 5'd31) begin
                        state      <= FETCH;
                        ready_q    <= 1'b1;
                        shift_en_q <= 1'b0;
                        head_q     <= 1'b0;
                    end else begin
                        head_q <= shreg[1];
                    end
                end

                VERIFY: begin
                    crc2_q  <= crc2_next;
                    ver_cnt <= ver_cnt + 16'd1;
                    if (ver_last) begin
                        crc_err_q  <= (crc2_next != crc_q);
                        loop_q     <= 1'b0;
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
module tb_ccff_prog_ctrl;

    logic        prog_clk  = 1'b0;
    logic        pReset    = 1'b1;
    logic        start     = 1'b0;
    logic [15:0] chain_len = '0;
    logic        verify_en = 1'b0;
    logic        ccff_head;
    logic        ccff_shift_en;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic        crc_err;
    logic [15:0] crc_value;

    ccff_prog_ctrl_if cfg_if ();

    ccff_prog_ctrl dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .chain_len     (chain_len),
        .verify_en     (verify_en),
        .cfg           (cfg_if),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .crc_err       (crc_err),
        .crc_value     (crc_value)
    );

    always #5 prog_clk = ~prog_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // ---------------- chain model: plain shift register, head in at [0], tail out at [len-1]
    logic [127:0] chain;
    int           chain_shifts = 0;
    int           m_len        = 0;
    int           shift_base   = 0;
    logic         flip_en      = 1'b0;
    int           flip_idx     = 0;
    logic         flip_now;

    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain        <= {chain[126:0], ccff_head};
            chain_shifts <= chain_shifts + 1;
        end
    end

    assign flip_now  = flip_en && ((chain_shifts - shift_base) == (m_len + flip_idx));
    assign ccff_tail = (m_len > 0) ? (chain[m_len-1] ^ flip_now) : 1'b0;

    // ---------------- word feeder
    logic [31:0] word_q[$];
    logic        hold       = 1'b0;
    logic        rand_stall = 1'b0;

    initial begin
        logic xfer;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        forever begin
            @(posedge prog_clk);
            xfer = cfg_if.cfg_valid && cfg_if.cfg_ready;
            #1;
            if (xfer && word_q.size() > 0) void'(word_q.pop_front());
            if (word_q.size() > 0 && !hold && (!rand_stall || $urandom_range(0, 3) != 0)) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_data  = word_q[0];
            end else begin
                cfg_if.cfg_valid = 1'b0;
                cfg_if.cfg_data  = $urandom;
            end
        end
    end

    // ---------------- pass description handed from stimulus to the model
    bit          n_bits[$];
    int          n_len;
    bit          n_ver, n_flip, n_relax;
    logic [15:0] n_crc;
    int          starts_req  = 0;
    int          pass_target = 0;

    // ---------------- model state, owned by the compare process
    bit          exp_bits[$];
    int          p_len;
    bit          p_ver, p_flip, p_relax;
    logic [15:0] p_crc;
    bit          pass_on     = 1'b0;
    int          prog_idx    = 0;
    int          ver_cnt     = 0;
    int          since_evt   = 0;
    logic [15:0] run_crc     = 16'hFFFF;
    bit          sticky_err  = 1'b0;
    int          starts_seen = 0;
    int          passes_done = 0;
    logic        rst_last    = 1'b1;

    always @(posedge prog_clk) rst_last <= pReset;

    initial begin
        forever begin
            @(negedge prog_clk);
            if (pReset || rst_last) begin
                pass_on     = 1'b0;
                run_crc     = 16'hFFFF;
                sticky_err  = 1'b0;
                starts_seen = starts_req;
            end else begin
                if (!pass_on && starts_seen != starts_req) begin
                    starts_seen = starts_req;
                    pass_on   = 1'b1;
                    p_len     = n_len;
                    p_ver     = n_ver;
                    p_flip    = n_flip;
                    p_relax   = n_relax;
                    p_crc     = n_crc;
                    exp_bits  = n_bits;
                    prog_idx  = 0;
                    ver_cnt   = 0;
                    since_evt = 0;
                    run_crc   = 16'hFFFF;
                end
                if (!pass_on) begin
                    chk("idle_busy",  busy, 0);
                    chk("idle_done",  done, 0);
                    chk("idle_shift", ccff_shift_en, 0);
                    chk("idle_ready", cfg_if.cfg_ready, 0);
                    chk("idle_head",  ccff_head, 0);
                    chk("idle_crc",   crc_value, run_crc);
                    chk("idle_err",   crc_err, sticky_err);
                end else begin
                    since_evt++;
                    chk("pass_busy", busy, 1);
                    chk("pass_crc", crc_value, run_crc);
                    if (!done) chk("pass_err", crc_err, 0);
                    if (ccff_shift_en) begin
                        chk("shift_ready", cfg_if.cfg_ready, 0);
                        chk("shift_done", done, 0);
                        if (prog_idx < p_len) begin
                            chk("head_bit", ccff_head, exp_bits[prog_idx]);
                            if (prog_idx % 32 == 0) begin
                                if (p_relax) chk("fetch_gap_min", since_evt >= 2, 1);
                                else         chk("fetch_gap", since_evt, 2);
                            end else begin
                                chk("word_gap", since_evt, 1);
                            end
                            run_crc = crc_step(run_crc, exp_bits[prog_idx]);
                            prog_idx++;
                        end else begin
                            chk("extra_shift", (p_ver && ver_cnt < p_len), 1);
                            chk("loop_head", ccff_head, ccff_tail);
                            chk("verify_gap", since_evt, 1);
                            ver_cnt++;
                        end
                        since_evt = 0;
                    end else begin
                        chk("gap_head", ccff_head, 0);
                        if (cfg_if.cfg_ready)
                            chk("ready_when", (prog_idx < p_len && prog_idx % 32 == 0), 1);
                    end
                    if (done) begin
                        chk("done_gap",  since_evt, 1);
                        chk("done_prog", prog_idx, p_len);
                        chk("done_ver",  ver_cnt, p_ver ? p_len : 0);
                        chk("done_crc",  crc_value, p_crc);
                        chk("done_err",  crc_err, p_flip);
                        if (!p_flip && p_len > 0) begin
                            bit ok;
                            ok = 1'b1;
                            for (int k = 0; k < p_len; k++)
                                if (chain[p_len-1-k] !== exp_bits[k]) ok = 1'b0;
                            chk("chain_keep", ok, 1);
                        end
                        sticky_err = p_flip;
                        pass_on    = 1'b0;
                        passes_done++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1 with the DUT idle)
    task automatic begin_pass(input int len, input bit ver, input bit flip, input int fidx,
                              input bit relax, input bit fw, input logic [31:0] w0);
        int          nw;
        logic [31:0] wd;
        logic [15:0] c;
        n_bits.delete();
        nw = (len + 31) / 32;
        for (int w = 0; w < nw; w++) begin
            wd = (w == 0 && fw) ? w0 : $urandom;
            word_q.push_back(wd);
            for (int b = 0; b < 32; b++)
                if (n_bits.size() < len) n_bits.push_back(wd[b]);
        end
        c = 16'hFFFF;
        foreach (n_bits[i]) c = crc_step(c, n_bits[i]);
        n_crc      = c;
        n_len      = len;
        n_ver      = ver;
        n_flip     = flip;
        n_relax    = relax;
        m_len      = len;
        flip_en    = flip;
        flip_idx   = fidx;
        shift_base = chain_shifts;
        pass_target = passes_done + 1;
        chain_len  = len[15:0];
        verify_en  = ver;
        start      = 1'b1;
        @(posedge prog_clk);
        #1;
        start     = 1'b0;
        chain_len = $urandom;
        verify_en = $urandom;
        starts_req++;
    endtask

    task automatic wait_pass(input int budget);
        int c;
        c = 0;
        while (passes_done < pass_target && c < budget) begin
            @(posedge prog_clk);
            c++;
        end
        #1;
        chk("pass_timeout", passes_done >= pass_target, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_ready"}, cfg_if.cfg_ready, 0);
        chk({tag, "_head"},  ccff_head, 0);
        chk({tag, "_shift"}, ccff_shift_en, 0);
        chk({tag, "_err"},   crc_err, 0);
        chk({tag, "_crc"},   crc_value, 16'hFFFF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, fidx;
        bit ver, flip, rs;

        // Reset, with start held high to show reset wins.
        pReset = 1'b1;
        start  = 1'b1;
        repeat (3) @(posedge prog_clk);
        #1;
        chk_reset_outputs("rst");
        pReset = 1'b0;
        start  = 1'b0;
        @(posedge prog_clk);
        #1;

        // 4-bit chain, no verify, word 0xA.
        begin_pass(4, 0, 0, 0, 0, 1, 32'h0000_000A);
        wait_pass(200);
        chk("model_crc_5eba", n_crc, 16'h5EBA);
        chk("dut_crc_5eba", crc_value, 16'h5EBA);
        chk("chain4_contents", chain[3:0], 4'b0101);

        // 40 bits, two words, clean verify.
        begin_pass(40, 1, 0, 0, 0, 0, 32'h0);
        wait_pass(400);
        chk("verify_clean_err", crc_err, 0);

        // 40 bits, verify with one corrupted tail bit; error is sticky.
        begin_pass(40, 1, 1, $urandom_range(0, 39), 0, 0, 32'h0);
        wait_pass(400);
        chk("verify_flip_err", crc_err, 1);
        repeat (5) @(posedge prog_clk);
        #1;
        chk("verify_err_sticky", crc_err, 1);

        // Zero-length chain.
        begin_pass(0, 1, 0, 0, 0, 0, 32'h0);
        wait_pass(50);
        chk("zero_len_err_cleared", crc_err, 0);

        // Reset during the shift of bit 10, then an immediate new pass.
        begin_pass(40, 0, 0, 0, 0, 0, 32'h0);
        repeat (10) @(posedge prog_clk);
        #1;
        chk("bit10_shift", ccff_shift_en, 1);
        chk("bit10_head", ccff_head, n_bits[9]);
        pReset = 1'b1;
        start  = 1'b1;
        @(posedge prog_clk);
        #1;
        chk_reset_outputs("midrst");
        pReset = 1'b0;
        start  = 1'b0;
        word_q.delete();
        begin_pass(4, 0, 0, 0, 0, 0, 32'h0);
        wait_pass(200);

        // Long FETCH stall with start pulses that must be ignored.
        hold = 1'b1;
        begin_pass(50, 1, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge prog_clk);
            chk("stall_ready", cfg_if.cfg_ready, 1);
            chk("stall_shift", ccff_shift_en, 0);
            chk("stall_head",  ccff_head, 0);
            start = (i % 4 == 1);
        end
        @(negedge prog_clk);
        start = 1'b0;
        hold  = 1'b0;
        wait_pass(600);

        // Randomized passes.
        for (int n = 0; n < 14; n++) begin
            len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 100);
            ver  = $urandom_range(0, 1);
            flip = ver && (len > 0) && ($urandom_range(0, 2) == 0);
            fidx = (len > 0) ? $urandom_range(0, len - 1) : 0;
            rs   = $urandom_range(0, 1);
            rand_stall = rs;
            begin_pass(len, ver, flip, fidx, rs, 0, 32'h0);
            wait_pass(2000);
            rand_stall = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge prog_clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
